// File: rtl/maj43_vote.sv
// Two-stage pipelined 43-input majority voter: group counts, then sum and compare.
// Define MAJ43_POPCNT_OUT_EN to expose the registered ones count on popcnt.
module maj43_vote #(
  parameter int unsigned THRESH = 22
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       x0,
  input  logic       x1,
  input  logic       x2,
  input  logic       x3,
  input  logic       x4,
  input  logic       x5,
  input  logic       x6,
  input  logic       x7,
  input  logic       x8,
  input  logic       x9,
  input  logic       x10,
  input  logic       x11,
  input  logic       x12,
  input  logic       x13,
  input  logic       x14,
  input  logic       x15,
  input  logic       x16,
  input  logic       x17,
  input  logic       x18,
  input  logic       x19,
  input  logic       x20,
  input  logic       x21,
  input  logic       x22,
  input  logic       x23,
  input  logic       x24,
  input  logic       x25,
  input  logic       x26,
  input  logic       x27,
  input  logic       x28,
  input  logic       x29,
  input  logic       x30,
  input  logic       x31,
  input  logic       x32,
  input  logic       x33,
  input  logic       x34,
  input  logic       x35,
  input  logic       x36,
  input  logic       x37,
  input  logic       x38,
  input  logic       x39,
  input  logic       x40,
  input  logic       x41,
  input  logic       x42,
  input  logic       in_valid,
  output logic       y0,
  output logic       out_valid
`ifdef MAJ43_POPCNT_OUT_EN
  ,
  output logic [5:0] popcnt
`endif
);

  localparam logic [5:0] THR = 6'(THRESH);

  typedef struct packed {
    logic [4:0][3:0] c8;
    logic [1:0]      c3;
  } s1_t;

  logic [42:0] x;
  s1_t         s1_d;
  s1_t         s1_q;
  logic        v1;
  logic [5:0]  total;

  assign x = {x42, x41, x40, x39, x38, x37, x36, x35,
              x34, x33, x32, x31, x30, x29, x28, x27,
              x26, x25, x24, x23, x22, x21, x20, x19,
              x18, x17, x16, x15, x14, x13, x12, x11,
              x10, x9,  x8,  x7,  x6,  x5,  x4,  x3,
              x2,  x1,  x0};

  function automatic logic [3:0] cnt8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + 4'(v[i]);
    return c;
  endfunction

  function automatic logic [1:0] cnt3(input logic [2:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

  always_comb begin
    s1_d = '0;
    for (int g = 0; g < 5; g++) s1_d.c8[g] = cnt8(x[g*8 +: 8]);
    s1_d.c3 = cnt3(x[42:40]);
  end

  // Partial counts hold on idle cycles so undriven inputs never leak forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      v1   <= 1'b0;
    end else begin
      v1 <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  always_comb begin
    total = 6'(s1_q.c3);
    for (int g = 0; g < 5; g++) total = total + 6'(s1_q.c8[g]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y0        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= v1;
      if (v1) y0 <= (total >= THR);
    end
  end

`ifdef MAJ43_POPCNT_OUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) popcnt <= 6'd0;
    else if (v1) popcnt <= total;
  end
`endif

endmodule

// File: tb/tb_maj43_vote.sv
// Directed and random checks of maj43_vote against a popcount reference model.
// Covers reset, threshold edges, extremes, placement, streaming and bubbles.
module tb_maj43_vote;

  localparam int THRESH = 22;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [42:0] x;
  logic        in_valid;
  logic        y0;
  logic        out_valid;
  logic [5:0]  popcnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic m_pv;
  int   m_pc;
  logic e_y;
  logic e_ov;
  int   e_cnt;

  always #5 clk = ~clk;

  maj43_vote #(.THRESH(THRESH)) dut (
    .clk(clk), .rst_n(rst_n),
    .x0(x[0]),   .x1(x[1]),   .x2(x[2]),   .x3(x[3]),
    .x4(x[4]),   .x5(x[5]),   .x6(x[6]),   .x7(x[7]),
    .x8(x[8]),   .x9(x[9]),   .x10(x[10]), .x11(x[11]),
    .x12(x[12]), .x13(x[13]), .x14(x[14]), .x15(x[15]),
    .x16(x[16]), .x17(x[17]), .x18(x[18]), .x19(x[19]),
    .x20(x[20]), .x21(x[21]), .x22(x[22]), .x23(x[23]),
    .x24(x[24]), .x25(x[25]), .x26(x[26]), .x27(x[27]),
    .x28(x[28]), .x29(x[29]), .x30(x[30]), .x31(x[31]),
    .x32(x[32]), .x33(x[33]), .x34(x[34]), .x35(x[35]),
    .x36(x[36]), .x37(x[37]), .x38(x[38]), .x39(x[39]),
    .x40(x[40]), .x41(x[41]), .x42(x[42]),
    .in_valid(in_valid),
    .y0(y0),
    .out_valid(out_valid)
`ifdef MAJ43_POPCNT_OUT_EN
    ,
    .popcnt(popcnt)
`endif
  );

`ifndef MAJ43_POPCNT_OUT_EN
  assign popcnt = 6'd0;
`endif

  function automatic logic [42:0] rnd43();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[42:0];
  endfunction

  task automatic chk(input string tag, input logic [5:0] obs,
                     input logic [5:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".out_valid"}, {5'd0, out_valid}, {5'd0, e_ov});
    chk({tag, ".y0"}, {5'd0, y0}, {5'd0, e_y});
`ifdef MAJ43_POPCNT_OUT_EN
    chk({tag, ".popcnt"}, popcnt, 6'(e_cnt));
`endif
  endtask

  task automatic model_reset();
    m_pv  = 1'b0;
    m_pc  = 0;
    e_y   = 1'b0;
    e_ov  = 1'b0;
    e_cnt = 0;
  endtask

  // Apply one vector, clock once, advance the model, compare.
  task automatic cycle(input string tag, input logic [42:0] v,
                       input logic vl);
    x        = v;
    in_valid = vl;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      e_ov = m_pv;
      if (m_pv) begin
        e_y   = (m_pc >= THRESH);
        e_cnt = m_pc;
      end
      m_pv = vl;
      if (vl) m_pc = $countones(v);
    end
    chk_all(tag);
  endtask

  logic [42:0] even_bits;

  initial begin
    model_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    x        = rnd43();
    #1;
    chk_all("reset_async");

    for (int i = 0; i < 4; i++) cycle("reset_hold", rnd43(), 1'b1);
    rst_n = 1'b1;

    cycle("post_rst_idle", rnd43(), 1'b0);
    cycle("post_rst_first", 43'h1F_FFFF, 1'b1);
    chk("first_ov_low", {5'd0, out_valid}, 6'd0);
    cycle("thr_22", 43'h3F_FFFF, 1'b1);
    chk("thr21_y0", {5'd0, y0}, 6'd0);
    cycle("zeros", 43'h0, 1'b1);
    chk("thr22_y0", {5'd0, y0}, 6'd1);
    cycle("ones", 43'h7FF_FFFF_FFFF, 1'b1);
    chk("zeros_y0", {5'd0, y0}, 6'd0);
    cycle("hi22", {22'h3F_FFFF, 21'h0}, 1'b1);
    chk("ones_y0", {5'd0, y0}, 6'd1);
    even_bits = '0;
    for (int i = 0; i < 43; i += 2) even_bits[i] = 1'b1;
    cycle("even22", even_bits, 1'b1);
    chk("hi22_y0", {5'd0, y0}, 6'd1);
    cycle("drain0", 43'h0, 1'b0);
    chk("even22_y0", {5'd0, y0}, 6'd1);
    cycle("drain1", 43'h0, 1'b0);

    cycle("bub_a", rnd43(), 1'b1);
    cycle("bub_b", rnd43(), 1'b0);
    cycle("bub_c", 'x, 1'b0);
    cycle("bub_d", rnd43(), 1'b1);
    cycle("bub_e", 'x, 1'b0);
    cycle("bub_f", 'x, 1'b0);
    cycle("bub_g", 'x, 1'b0);

    for (int i = 0; i < 1000; i++) cycle("stream", rnd43(), 1'b1);

    cycle("mid_a", 43'h7FF_FFFF_FFFF, 1'b1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("mid_rst_async");
    cycle("mid_hold", rnd43(), 1'b1);
    rst_n = 1'b1;
    cycle("mid_post0", 43'h7FF_FFFF_FFFF, 1'b1);
    cycle("mid_post1", 43'h0, 1'b0);
    cycle("mid_post2", 43'h0, 1'b0);

    for (int i = 0; i < 200; i++)
      cycle("rand_gap", rnd43(), 1'($urandom_range(0, 1)));
    cycle("tail0", 'x, 1'b0);
    cycle("tail1", 'x, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
